// File: rtl/axi_intr_ctrl_pkg.sv
// Shared definitions for the multi-source AXI4-Lite interrupt controller:
// register word indices, response code and channel FSM states.
package axi_intr_ctrl_pkg;

  // Word index (byte address [4:2]) of each register
  localparam logic [2:0] REG_GIE    = 3'd0;
  localparam logic [2:0] REG_IER    = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ACK    = 3'd3;
  localparam logic [2:0] REG_PEND   = 3'd4;
  localparam logic [2:0] REG_MODE   = 3'd5;
  localparam logic [2:0] REG_ID     = 3'd6;

  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_intr_ctrl_multi_capture_lane.sv
// One interrupt channel: registered source (also the edge history),
// level/rising-edge capture and a pending bit where a new set beats a clear.
module intr_capture_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic enable,
  input  logic edge_mode,
  input  logic clr,
  output logic status,
  output logic pend
);

  logic set;

  assign set = enable & (edge_mode ? (src & ~status) : src);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= 1'b0;
      pend   <= 1'b0;
    end else begin
      status <= src;
      pend   <= (pend & ~clr) | set;
    end
  end

endmodule

// File: rtl/axi_intr_ctrl_multi.sv
// AXI4-Lite interrupt controller aggregating up to 32 synchronous sources
// onto one irq line with per-channel edge/level capture and a pending-ID view.
module axi_intr_ctrl_multi
  import axi_intr_ctrl_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 4,
  parameter int C_IRQ_SENSITIVITY  = 0,
  parameter int C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  output logic                            irq
);

  localparam int   N   = C_NUM_OF_INTR;
  localparam logic ACT = (C_IRQ_ACTIVE_STATE != 0);

  wr_state_t      wr_state_reg;
  rd_state_t      rd_state_reg;
  logic           aw_ready_reg, w_ready_reg, b_valid_reg, ar_ready_reg, r_valid_reg;
  logic [31:0]    r_data_reg;
  logic           gie_reg, any_reg, irq_reg;
  logic [N-1:0]   ier_reg, mode_reg, status, pend, clr, wmask;
  logic [31:0]    strb_mask, ier_ext, mode_ext, status_ext, pend_ext, id_word, rd_mux;
  logic [4:0]     pend_idx;
  logic [2:0]     wr_idx, rd_idx;
  logic           wr_en, any_next, irq_fire;

  genvar gi;
  for (gi = 0; gi < 32; gi++) begin : g_strb
    assign strb_mask[gi] = S_AXI_WSTRB[gi/8];
  end

  assign wmask  = strb_mask[N-1:0];
  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];
  // Both readies are only ever high together in W_IDLE, so this marks the handshake edge
  assign wr_en  = aw_ready_reg & (wr_state_reg == W_IDLE);
  assign clr    = (wr_en && wr_idx == REG_ACK) ? (S_AXI_WDATA[N-1:0] & wmask) : '0;

  for (gi = 0; gi < N; gi++) begin : g_lane
    intr_capture_lane u_lane (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .src       (intr_src[gi]),
      .enable    (ier_reg[gi]),
      .edge_mode (mode_reg[gi]),
      .clr       (clr[gi]),
      .status    (status[gi]),
      .pend      (pend[gi])
    );
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      gie_reg  <= 1'b0;
      ier_reg  <= '0;
      mode_reg <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        REG_GIE:  if (S_AXI_WSTRB[0]) gie_reg <= S_AXI_WDATA[0];
        REG_IER:  ier_reg  <= (ier_reg & ~wmask) | (S_AXI_WDATA[N-1:0] & wmask);
        REG_MODE: mode_reg <= (mode_reg & ~wmask) | (S_AXI_WDATA[N-1:0] & wmask);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state_reg <= W_IDLE;
      aw_ready_reg <= 1'b0;
      w_ready_reg  <= 1'b0;
      b_valid_reg  <= 1'b0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (aw_ready_reg) begin
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            b_valid_reg  <= 1'b1;
            wr_state_reg <= W_RESP;
          end else if (S_AXI_AWVALID && S_AXI_WVALID && !b_valid_reg) begin
            aw_ready_reg <= 1'b1;
            w_ready_reg  <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            b_valid_reg  <= 1'b0;
            wr_state_reg <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    pend_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) pend_idx = 5'(i);
    end
  end

  always_comb begin
    ier_ext    = '0;
    mode_ext   = '0;
    status_ext = '0;
    pend_ext   = '0;
    ier_ext[N-1:0]    = ier_reg;
    mode_ext[N-1:0]   = mode_reg;
    status_ext[N-1:0] = status;
    pend_ext[N-1:0]   = pend;
  end

  assign id_word = {|pend, 26'b0, pend_idx};

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_GIE:    rd_mux = {31'b0, gie_reg};
      REG_IER:    rd_mux = ier_ext;
      REG_STATUS: rd_mux = status_ext;
      REG_PEND:   rd_mux = pend_ext;
      REG_MODE:   rd_mux = mode_ext;
      REG_ID:     rd_mux = id_word;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state_reg <= R_IDLE;
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (ar_ready_reg) begin
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b1;
            r_data_reg   <= rd_mux;
            rd_state_reg <= R_DATA;
          end else if (S_AXI_ARVALID && !r_valid_reg) begin
            ar_ready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_valid_reg  <= 1'b0;
            rd_state_reg <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Pulse mode fires only on the rising edge of the aggregated request
  assign any_next = gie_reg & (|pend);
  assign irq_fire = (C_IRQ_SENSITIVITY == 0) ? any_next : (any_next & ~any_reg);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      any_reg <= 1'b0;
      irq_reg <= ~ACT;
    end else begin
      any_reg <= any_next;
      irq_reg <= irq_fire ? ACT : ~ACT;
    end
  end

  assign S_AXI_AWREADY = aw_ready_reg;
  assign S_AXI_WREADY  = w_ready_reg;
  assign S_AXI_BVALID  = b_valid_reg;
  assign S_AXI_BRESP   = OKAY;
  assign S_AXI_ARREADY = ar_ready_reg;
  assign S_AXI_RVALID  = r_valid_reg;
  assign S_AXI_RDATA   = r_data_reg;
  assign S_AXI_RRESP   = OKAY;
  assign irq           = irq_reg;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                       S_AXI_WDATA, strb_mask};

endmodule
